ofdm_symbol_mapper_ctrl: RTL and testbench
==========================================

Name: ofdm_symbol_mapper_ctrl

Overview:
Sequences one 64-subcarrier OFDM symbol through the constellation mapper (modulation, combinational; inputs N_BPSC and bits_in[5:0], output IQ[31:0] = {I[15:0], Q[15:0]}).
Pulls interleaved coded bits from the interleaver, groups N_BPSC bits per data subcarrier, and inserts pilots and nulls.
Emits 64 IQ words in natural IFFT order (index 0..63) to the IFFT input stage under a valid/ready handshake.

Parameters:
N_SC, 64, subcarriers per symbol (fixed; index counter is 6 bits)
PILOT_POS, 16'h4000, I value for a +1 pilot (Q = 0)
PILOT_NEG, 16'hC000, I value for a -1 pilot (Q = 0)

Ports:
clk  in  1  system clock
rstn  in  1  synchronous active-low reset
sym_start  in  1  one-cycle pulse; begin a symbol (accepted only in IDLE)
sym_n_bpsc  in  3  bits per subcarrier for this symbol; valid values 1, 2, 4, 6; sampled on sym_start
sym_pilot_pol  in  1  pilot polarity for this symbol; 1 inverts all pilots; sampled on sym_start
bit_in  in  1  coded bit from interleaver
bit_valid  in  1  bit_in valid
bit_ready  out  1  bit accepted when bit_valid && bit_ready
iq_out  out  32  {I, Q}, Q15
iq_idx  out  6  subcarrier index of iq_out
iq_valid  out  1  iq_out valid
iq_last  out  1  high with index 63
iq_ready  in  1  downstream ready
busy  out  1  symbol in progress
cfg_err  out  1  one-cycle pulse on sym_start with an invalid sym_n_bpsc

Behaviour:
- Reset (rstn = 0 at a clk edge): state IDLE; all outputs 0; index counter, bit counter and shift register cleared. Reset mid-symbol aborts the symbol; no partial output after release.
- Subcarrier classes by index k:
  - null: k = 0 and k = 27..37
  - pilot: k = 7, 21, 43 carry +1; k = 57 carries -1; all four are negated when pol = 1
  - data: the remaining 48
- States:
  - IDLE: busy = 0, bit_ready = 0. On sym_start with n_bpsc in {1,2,4,6}: latch n_bpsc and pol, k = 0, go to CLASSIFY. On an invalid value: pulse cfg_err, stay in IDLE.
  - CLASSIFY: if k is data, go to GATHER with bit count = 0. Otherwise register the pilot or null word (null = 32'h0; pilot = {PILOT_POS or PILOT_NEG, 16'h0}) into iq_out and go to EMIT.
  - GATHER: bit_ready = 1. Each accepted bit j (0-based within the group) goes to bits[j]; the first bit lands in bit 0. On the handshake of bit n_bpsc-1: register the modulation output, driven with the latched n_bpsc and the completed bits, into iq_out and go to EMIT. bit_valid low stalls with no timeout.
  - EMIT: iq_valid = 1; iq_out, iq_idx and iq_last are held stable until iq_ready. On iq_valid && iq_ready: if k = 63 go to IDLE, else k = k + 1 and go to CLASSIFY.
- bit_ready is 0 outside GATHER, so no bits are consumed on pilot or null subcarriers.
- Exactly 48 × n_bpsc bits are consumed per symbol: 48, 96, 192 or 288.
- busy = 1 in every state except IDLE.
- sym_start outside IDLE is ignored (no error pulse).
- Latency: a non-data subcarrier is presented 1 cycle after CLASSIFY. A data subcarrier is presented 1 cycle after its last bit handshake.
- With bit_valid and iq_ready held high, the symbol finishes in 64 × 2 + 48 × n_bpsc cycles.
- iq_out keeps its last value while iq_valid = 0.

Decomposition:
- Shared package ofdm_tx_pkg holds:
  - N_SC, null and pilot index constants
  - pilot I values
  - the valid n_bpsc encodings (1, 2, 4, 6)
  - a state enum (IDLE, CLASSIFY, GATHER, EMIT)
- One sub-module: the existing combinational modulation, instantiated once. Its N_BPSC is tied to the latched n_bpsc and its bits_in to the gathered shift register.

Test Plan:
- BPSK, pol = 0, 48 bits all 1, iq_ready = 1:
  - k = 1 gives 32'h40000000
  - k = 0 and k = 27 give 32'h0
  - k = 7 gives 32'h40000000; k = 57 gives 32'hC0000000
  - iq_last only at k = 63; exactly 48 bit handshakes.
- QPSK, pol = 1, bits 1,0 repeated:
  - data words are 32'h2D41D2BF
  - k = 7 gives 32'hC0000000; k = 57 gives 32'h40000000
  - 96 bits consumed.
- 64-QAM, first group 1,0,0,0,0,0 then zeros:
  - k = 1 gives 32'h4520BAE0
  - other data subcarriers give 32'hBAE0BAE0
  - 288 bits consumed; busy falls after index 63.
- Backpressure: hold iq_ready = 0 for 5 cycles at k = 5 → iq_out and iq_idx stable, bit_ready = 0, no extra bits consumed. Starve bit_valid for 10 cycles mid-group → no output and no state change.
- sym_n_bpsc = 3 → cfg_err pulses one cycle, busy stays 0. sym_start mid-symbol → ignored.
- rstn = 0 at k = 30, then a new 16-QAM symbol → restarts at k = 0; outputs are all 0 during reset.

Source files
------------

// File: rtl/ofdm_tx_pkg.sv
// Shared constants, subcarrier classification helpers and controller state
// encoding for the OFDM transmit symbol path.
package ofdm_tx_pkg;

    localparam int         N_SC   = 64;
    localparam logic [5:0] K_LAST = 6'(N_SC - 1);

    localparam logic [5:0] NULL_DC = 6'd0;
    localparam logic [5:0] NULL_LO = 6'd27;
    localparam logic [5:0] NULL_HI = 6'd37;

    localparam logic [5:0] PILOT_K0 = 6'd7;
    localparam logic [5:0] PILOT_K1 = 6'd21;
    localparam logic [5:0] PILOT_K2 = 6'd43;
    localparam logic [5:0] PILOT_K3 = 6'd57;

    localparam logic [15:0] PILOT_POS = 16'h4000;
    localparam logic [15:0] PILOT_NEG = 16'hC000;

    localparam logic [2:0] NBPSC_BPSK  = 3'd1;
    localparam logic [2:0] NBPSC_QPSK  = 3'd2;
    localparam logic [2:0] NBPSC_QAM16 = 3'd4;
    localparam logic [2:0] NBPSC_QAM64 = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLASSIFY,
        ST_GATHER,
        ST_EMIT
    } state_t;

    function automatic logic is_null_sc(input logic [5:0] k);
        return (k == NULL_DC) || ((k >= NULL_LO) && (k <= NULL_HI));
    endfunction

    function automatic logic is_pilot_sc(input logic [5:0] k);
        return (k == PILOT_K0) || (k == PILOT_K1) || (k == PILOT_K2) || (k == PILOT_K3);
    endfunction

    // Pilot at 57 is inherently -1; symbol polarity flips all four.
    function automatic logic [31:0] pilot_word(input logic [5:0] k, input logic pol);
        logic neg;
        neg = (k == PILOT_K3) ^ pol;
        return {(neg ? PILOT_NEG : PILOT_POS), 16'h0000};
    endfunction

    function automatic logic n_bpsc_ok(input logic [2:0] n);
        return (n == NBPSC_BPSK) || (n == NBPSC_QPSK) || (n == NBPSC_QAM16) || (n == NBPSC_QAM64);
    endfunction

endpackage

// File: rtl/modulation.sv
// Combinational Gray-coded constellation mapper (BPSK/QPSK/16-QAM/64-QAM).
// bits_in[0] is the first bit of the group; output is {I, Q} in Q15, truncated.
module modulation
    import ofdm_tx_pkg::*;
(
    input  logic [2:0]  N_BPSC,
    input  logic [5:0]  bits_in,
    output logic [31:0] IQ
);

    // Unit-average-power levels at half scale: 0.5 * level / sqrt(norm).
    localparam logic [15:0] AMP_BPSK = 16'd16384;
    localparam logic [15:0] AMP_QPSK = 16'd11585;
    localparam logic [15:0] AMP_16_1 = 16'd5181;
    localparam logic [15:0] AMP_16_3 = 16'd15543;
    localparam logic [15:0] AMP_64_1 = 16'd2528;
    localparam logic [15:0] AMP_64_3 = 16'd7584;
    localparam logic [15:0] AMP_64_5 = 16'd12640;
    localparam logic [15:0] AMP_64_7 = 16'd17696;

    function automatic logic [15:0] apply_sign(input logic pos, input logic [15:0] mag);
        return pos ? mag : (~mag + 16'd1);
    endfunction

    function automatic logic [15:0] qam16_mag(input logic b);
        return b ? AMP_16_1 : AMP_16_3;
    endfunction

    function automatic logic [15:0] qam64_mag(input logic [1:0] b);
        logic [15:0] m;
        case (b)
            2'b00:   m = AMP_64_7;
            2'b01:   m = AMP_64_5;
            2'b11:   m = AMP_64_3;
            default: m = AMP_64_1;
        endcase
        return m;
    endfunction

    always_comb begin
        IQ = '0;
        case (N_BPSC)
            NBPSC_BPSK:  IQ = {apply_sign(bits_in[0], AMP_BPSK), 16'h0000};
            NBPSC_QPSK:  IQ = {apply_sign(bits_in[0], AMP_QPSK),
                               apply_sign(bits_in[1], AMP_QPSK)};
            NBPSC_QAM16: IQ = {apply_sign(bits_in[0], qam16_mag(bits_in[1])),
                               apply_sign(bits_in[2], qam16_mag(bits_in[3]))};
            NBPSC_QAM64: IQ = {apply_sign(bits_in[0], qam64_mag({bits_in[1], bits_in[2]})),
                               apply_sign(bits_in[3], qam64_mag({bits_in[4], bits_in[5]}))};
            default:     IQ = '0;
        endcase
    end

endmodule

// File: rtl/ofdm_symbol_mapper_ctrl.sv
// Walks subcarriers 0..63 of one OFDM symbol, gathering coded bits for data
// carriers, inserting pilots/nulls, and presenting each IQ word under valid/ready.
module ofdm_symbol_mapper_ctrl
    import ofdm_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        sym_start,
    input  logic [2:0]  sym_n_bpsc,
    input  logic        sym_pilot_pol,
    input  logic        bit_in,
    input  logic        bit_valid,
    output logic        bit_ready,
    output logic [31:0] iq_out,
    output logic [5:0]  iq_idx,
    output logic        iq_valid,
    output logic        iq_last,
    input  logic        iq_ready,
    output logic        busy,
    output logic        cfg_err
);

    state_t      state, state_next;
    logic [5:0]  k;
    logic [2:0]  bit_cnt;
    logic [2:0]  n_bpsc;
    logic        pol;
    logic [5:0]  bits_sr;
    logic [5:0]  bits_full;
    logic [31:0] mod_iq;
    logic        is_data;
    logic        start_ok;
    logic        bit_hs;
    logic        group_done;

    assign is_data    = !is_null_sc(k) && !is_pilot_sc(k);
    assign start_ok   = sym_start && n_bpsc_ok(sym_n_bpsc);
    assign bit_hs     = (state == ST_GATHER) && bit_valid;
    assign group_done = bit_hs && (bit_cnt == (n_bpsc - 3'd1));

    assign busy      = (state != ST_IDLE);
    assign bit_ready = (state == ST_GATHER);
    assign iq_valid  = (state == ST_EMIT);
    assign iq_last   = iq_valid && (k == K_LAST);
    assign iq_idx    = k;

    // The mapper sees the group including the bit being accepted this cycle,
    // so the word can be registered on the last handshake.
    always_comb begin
        bits_full = bits_sr;
        for (int i = 0; i < 6; i++) begin
            if (3'(i) == bit_cnt) bits_full[i] = bit_in;
        end
    end

    modulation u_modulation (
        .N_BPSC  (n_bpsc),
        .bits_in (bits_full),
        .IQ      (mod_iq)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (start_ok) state_next = ST_CLASSIFY;
            ST_CLASSIFY: state_next = is_data ? ST_GATHER : ST_EMIT;
            ST_GATHER:   if (group_done) state_next = ST_EMIT;
            ST_EMIT:     if (iq_ready) state_next = (k == K_LAST) ? ST_IDLE : ST_CLASSIFY;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            k       <= '0;
            bit_cnt <= '0;
            bits_sr <= '0;
            n_bpsc  <= '0;
            pol     <= 1'b0;
            iq_out  <= '0;
            cfg_err <= 1'b0;
        end else begin
            state   <= state_next;
            cfg_err <= (state == ST_IDLE) && sym_start && !n_bpsc_ok(sym_n_bpsc);
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        n_bpsc <= sym_n_bpsc;
                        pol    <= sym_pilot_pol;
                        k      <= '0;
                    end
                end
                ST_CLASSIFY: begin
                    bit_cnt <= '0;
                    bits_sr <= '0;
                    if (!is_data) iq_out <= is_pilot_sc(k) ? pilot_word(k, pol) : 32'h0;
                end
                ST_GATHER: begin
                    if (bit_hs) begin
                        bits_sr <= bits_full;
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    if (group_done) iq_out <= mod_iq;
                end
                ST_EMIT: begin
                    if (iq_ready && (k != K_LAST)) k <= k + 6'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ofdm_symbol_mapper_ctrl.sv
// Directed bench for ofdm_symbol_mapper_ctrl: one linear sequence of steps,
// expected IQ words and counts computed by hand from the constellation tables.
module tb_ofdm_symbol_mapper_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        sym_start = 1'b0;
    logic [2:0]  sym_n_bpsc = 3'd0;
    logic        sym_pilot_pol = 1'b0;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic        bit_ready;
    logic [31:0] iq_out;
    logic [5:0]  iq_idx;
    logic        iq_valid;
    logic        iq_last;
    logic        iq_ready = 1'b0;
    logic        busy;
    logic        cfg_err;

    ofdm_symbol_mapper_ctrl dut (
        .clk           (clk),
        .rstn          (rstn),
        .sym_start     (sym_start),
        .sym_n_bpsc    (sym_n_bpsc),
        .sym_pilot_pol (sym_pilot_pol),
        .bit_in        (bit_in),
        .bit_valid     (bit_valid),
        .bit_ready     (bit_ready),
        .iq_out        (iq_out),
        .iq_idx        (iq_idx),
        .iq_valid      (iq_valid),
        .iq_last       (iq_last),
        .iq_ready      (iq_ready),
        .busy          (busy),
        .cfg_err       (cfg_err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          n_bits, words, last_count, order_err, first_idx, mode;
    logic [31:0] cap_iq [64];
    logic        cap_last [64];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // 0: all ones; 1: 1,0 repeated; 2: only the first bit of the symbol set.
    function automatic logic pattern_bit(input int m, input int n);
        case (m)
            0:       return 1'b1;
            1:       return (n % 2) == 0;
            2:       return n == 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic tick();
        logic        bit_hs, iq_hs, last_pre;
        logic [31:0] iq_pre;
        logic [5:0]  idx_pre;
        bit_hs   = bit_valid && bit_ready;
        iq_hs    = iq_valid && iq_ready;
        iq_pre   = iq_out;
        idx_pre  = iq_idx;
        last_pre = iq_last;
        @(posedge clk);
        #1;
        if (bit_hs) n_bits++;
        if (iq_hs) begin
            if (words == 0) first_idx = int'(idx_pre);
            if (int'(idx_pre) != words) order_err++;
            cap_iq[idx_pre]   = iq_pre;
            cap_last[idx_pre] = last_pre;
            if (last_pre) last_count++;
            words++;
        end
        bit_in = pattern_bit(mode, n_bits);
    endtask

    task automatic start_symbol(input logic [2:0] nb, input logic pol, input int m);
        mode = m;
        n_bits = 0;
        words = 0;
        last_count = 0;
        order_err = 0;
        first_idx = -1;
        for (int i = 0; i < 64; i++) begin
            cap_iq[i]   = 32'hxxxx_xxxx;
            cap_last[i] = 1'bx;
        end
        bit_in = pattern_bit(m, 0);
        sym_n_bpsc = nb;
        sym_pilot_pol = pol;
        sym_start = 1'b1;
        tick();
        sym_start = 1'b0;
    endtask

    task automatic finish_symbol(output int cyc);
        cyc = 0;
        while (busy && cyc < 2000) begin
            tick();
            cyc++;
        end
    endtask

    task automatic wait_idx(input logic [5:0] target, output logic found);
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            if (iq_valid && iq_idx == target) found = 1'b1;
            else tick();
        end
    endtask

    initial begin
        int          cyc;
        logic        found, stable;
        logic [31:0] hold_iq;

        mode = 0;
        n_bits = 0;
        words = 0;
        last_count = 0;
        order_err = 0;
        first_idx = -1;

        // Reset state
        repeat (3) tick();
        check("rst_iq_out", iq_out, 32'h0);
        check("rst_iq_idx", 32'(iq_idx), 32'd0);
        check("rst_iq_valid", 32'(iq_valid), 32'd0);
        check("rst_iq_last", 32'(iq_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bit_ready", 32'(bit_ready), 32'd0);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);
        rstn = 1'b1;
        bit_valid = 1'b1;
        iq_ready = 1'b1;
        tick();

        // BPSK, pol 0, all ones
        start_symbol(3'd1, 1'b0, 0);
        finish_symbol(cyc);
        check("bpsk_k1", cap_iq[1], 32'h4000_0000);
        check("bpsk_k0", cap_iq[0], 32'h0);
        check("bpsk_k27", cap_iq[27], 32'h0);
        check("bpsk_k7", cap_iq[7], 32'h4000_0000);
        check("bpsk_k21", cap_iq[21], 32'h4000_0000);
        check("bpsk_k57", cap_iq[57], 32'hC000_0000);
        check("bpsk_last63", 32'(cap_last[63]), 32'd1);
        check("bpsk_last_count", 32'(last_count), 32'd1);
        check("bpsk_bits", 32'(n_bits), 32'd48);
        check("bpsk_words", 32'(words), 32'd64);
        check("bpsk_order", 32'(order_err), 32'd0);
        check("bpsk_cycles", 32'(cyc), 32'd176);

        // QPSK, pol 1, bits 1,0 repeated
        start_symbol(3'd2, 1'b1, 1);
        finish_symbol(cyc);
        check("qpsk_k1", cap_iq[1], 32'h2D41_D2BF);
        check("qpsk_k63", cap_iq[63], 32'h2D41_D2BF);
        check("qpsk_k7", cap_iq[7], 32'hC000_0000);
        check("qpsk_k57", cap_iq[57], 32'h4000_0000);
        check("qpsk_k32", cap_iq[32], 32'h0);
        check("qpsk_bits", 32'(n_bits), 32'd96);
        check("qpsk_cycles", 32'(cyc), 32'd224);

        // 64-QAM, first group 1,0,0,0,0,0 then zeros
        start_symbol(3'd6, 1'b0, 2);
        finish_symbol(cyc);
        check("qam64_k1", cap_iq[1], 32'h4520_BAE0);
        check("qam64_k2", cap_iq[2], 32'hBAE0_BAE0);
        check("qam64_k62", cap_iq[62], 32'hBAE0_BAE0);
        check("qam64_bits", 32'(n_bits), 32'd288);
        check("qam64_busy_end", 32'(busy), 32'd0);
        check("qam64_words", 32'(words), 32'd64);
        check("qam64_cycles", 32'(cyc), 32'd416);

        // Invalid n_bpsc in IDLE
        sym_n_bpsc = 3'd3;
        sym_start = 1'b1;
        tick();
        sym_start = 1'b0;
        check("cfg_err_pulse", 32'(cfg_err), 32'd1);
        check("cfg_err_busy", 32'(busy), 32'd0);
        tick();
        check("cfg_err_clear", 32'(cfg_err), 32'd0);
        check("cfg_err_idle", 32'(busy), 32'd0);

        // 16-QAM with output backpressure at k=5 and bit starvation mid-group
        start_symbol(3'd4, 1'b0, 0);
        wait_idx(6'd5, found);
        check("bp_reach_k5", 32'(found), 32'd1);
        iq_ready = 1'b0;
        hold_iq = iq_out;
        stable = 1'b1;
        repeat (5) begin
            tick();
            if (iq_out !== hold_iq || iq_idx !== 6'd5 || bit_ready !== 1'b0 || iq_valid !== 1'b1)
                stable = 1'b0;
        end
        check("bp_stable", 32'(stable), 32'd1);
        check("bp_word", hold_iq, 32'h143D_143D);
        check("bp_bits", 32'(n_bits), 32'd20);
        iq_ready = 1'b1;

        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (bit_ready && (n_bits % 4) == 2) found = 1'b1;
            else tick();
        end
        check("starve_reach", 32'(found), 32'd1);
        bit_valid = 1'b0;
        stable = 1'b1;
        repeat (10) begin
            tick();
            if (iq_valid !== 1'b0 || bit_ready !== 1'b1) stable = 1'b0;
        end
        check("starve_hold", 32'(stable), 32'd1);
        check("starve_bits", 32'(n_bits), 32'd22);
        bit_valid = 1'b1;

        sym_n_bpsc = 3'd3;
        sym_start = 1'b1;
        tick();
        sym_start = 1'b0;
        check("midsym_no_err", 32'(cfg_err), 32'd0);
        check("midsym_busy", 32'(busy), 32'd1);
        finish_symbol(cyc);
        check("qam16_k1", cap_iq[1], 32'h143D_143D);
        check("qam16_k63", cap_iq[63], 32'h143D_143D);
        check("qam16_k43", cap_iq[43], 32'h4000_0000);
        check("qam16_bits", 32'(n_bits), 32'd192);
        check("qam16_words", 32'(words), 32'd64);
        check("qam16_last_count", 32'(last_count), 32'd1);

        // Reset in the middle of a symbol, then a fresh 16-QAM symbol
        start_symbol(3'd4, 1'b0, 0);
        wait_idx(6'd30, found);
        check("rst_reach_k30", 32'(found), 32'd1);
        rstn = 1'b0;
        tick();
        check("midrst_iq_out", iq_out, 32'h0);
        check("midrst_iq_valid", 32'(iq_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_bit_ready", 32'(bit_ready), 32'd0);
        check("midrst_iq_idx", 32'(iq_idx), 32'd0);
        tick();
        rstn = 1'b1;
        words = 0;
        repeat (3) tick();
        check("postrst_no_words", 32'(words), 32'd0);
        check("postrst_idle", 32'(busy), 32'd0);

        start_symbol(3'd4, 1'b0, 1);
        finish_symbol(cyc);
        check("restart_first_idx", 32'(first_idx), 32'd0);
        check("restart_k1", cap_iq[1], 32'h3CB7_3CB7);
        check("restart_k2", cap_iq[2], 32'h3CB7_3CB7);
        check("restart_bits", 32'(n_bits), 32'd192);
        check("restart_words", 32'(words), 32'd64);
        check("restart_order", 32'(order_err), 32'd0);
        check("restart_cycles", 32'(cyc), 32'd320);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
